// File: rtl/pps_burst_clkgen.sv
// ---------------------------------------------------------------------------
// pps_burst_clkgen
//
// Multi-channel clock and trigger generator that starts on a PPS edge. Each
// channel latches a divide ratio and a burst length when it arms on a transmit
// request. It starts on the next synchronised PPS rising edge, then produces a
// 50% duty clock and a one-cycle tick at the start of every output period.
// A finite burst ends with a done pulse. A burst length of zero runs until
// the channel is aborted.
//
// Ports:
//   clock      10 MHz reference; all logic runs on its rising edge
//   reset_n    asynchronous active-low reset
//   pps        raw 1 Hz pulse, asynchronous to clock
//   div_ratio  per-channel clock cycles per period, CNT_W bits per channel
//   burst_len  per-channel periods per burst (0 = continuous), BURST_W bits
//   txrq       per-channel transmit request (level)
//   abort      per-channel abort (level)
//   busy       channel is armed or running
//   clk_out    generated clock
//   tick       one-cycle pulse at the start of each period
//   done       one-cycle pulse when a finite burst completes
// ---------------------------------------------------------------------------
module pps_burst_clkgen #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 24,
  parameter int BURST_W = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       pps,
  input  logic [NUM_CH*CNT_W-1:0]    div_ratio,
  input  logic [NUM_CH*BURST_W-1:0]  burst_len,
  input  logic [NUM_CH-1:0]          txrq,
  input  logic [NUM_CH-1:0]          abort,
  output logic [NUM_CH-1:0]          busy,
  output logic [NUM_CH-1:0]          clk_out,
  output logic [NUM_CH-1:0]          tick,
  output logic [NUM_CH-1:0]          done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  logic pps_sync1;
  logic pps_sync2;
  logic pps_sync3;
  logic pps_edge;

  // Two flops resynchronise the raw PPS. The third flop delays the
  // synchronised level by one cycle so that a rising edge gives exactly one
  // pulse, however long pps stays high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pps_sync1 <= 1'b0;
      pps_sync2 <= 1'b0;
      pps_sync3 <= 1'b0;
    end else begin
      pps_sync1 <= pps;
      pps_sync2 <= pps_sync1;
      pps_sync3 <= pps_sync2;
    end
  end

  assign pps_edge = pps_sync2 & ~pps_sync3;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic               clk_q, clk_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   div_in;
    logic [CNT_W-1:0]   div_sat;
    logic [BURST_W-1:0] len_in;
    logic               wrap;

    assign div_in  = div_ratio[i*CNT_W +: CNT_W];
    assign len_in  = burst_len[i*BURST_W +: BURST_W];
    // A period shorter than two cycles cannot have both a high phase and a
    // low phase, so ratios of 0 and 1 run as 2.
    assign div_sat = (div_in < CNT_W'(2)) ? CNT_W'(2) : div_in;
    assign wrap    = (cnt_q == div_q - CNT_W'(1));

    // Register stage for the channel state, counters, latched parameters
    // and outputs.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        div_q   <= '0;
        rem_q   <= '0;
        len_q   <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        rem_q   <= rem_d;
        len_q   <= len_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
        done_q  <= done_d;
      end
    end

    // Next-state and output logic. An abort during RUN also blocks the
    // outputs for that cycle, so clk_out and tick fall together with busy
    // and no done pulse appears.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      rem_d   = rem_q;
      len_d   = len_q;
      clk_d   = 1'b0;
      tick_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          rem_d = '0;
          if (txrq[i] && !abort[i]) begin
            state_d = ST_ARMED;
            div_d   = div_sat;
            len_d   = len_in;
          end
        end
        ST_ARMED: begin
          if (abort[i]) begin
            state_d = ST_IDLE;
          end else if (pps_edge) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            rem_d   = len_q;
          end
        end
        ST_RUN: begin
          if (abort[i]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rem_d   = '0;
          end else begin
            tick_d = (cnt_q == '0);
            clk_d  = (cnt_q < (div_q >> 1));
            if (wrap) begin
              cnt_d = '0;
              if (len_q != '0) begin
                rem_d = rem_q - BURST_W'(1);
                if (rem_q == BURST_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
                end
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rem_d   = '0;
        end
      endcase
    end

    // busy follows the state register directly. It drops on the first idle
    // cycle, the same cycle as done.
    assign busy[i]    = (state_q != ST_IDLE);
    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign done[i]    = done_q;
  end

endmodule

// File: tb/tb_pps_burst_clkgen.sv
// ---------------------------------------------------------------------------
// tb_pps_burst_clkgen
//
// Directed testbench for pps_burst_clkgen. Each scenario arms a channel,
// fires a PPS pulse and then steps through a window of cycles after the
// pps_edge cycle T. Hand-computed bit masks give the expected outputs: bit k
// of a mask is the expected value at cycle T+k.
// ---------------------------------------------------------------------------
module tb_pps_burst_clkgen;

  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 24;
  localparam int BURST_W = 16;

  logic                      clock;
  logic                      reset_n;
  logic                      pps;
  logic [NUM_CH*CNT_W-1:0]   div_ratio;
  logic [NUM_CH*BURST_W-1:0] burst_len;
  logic [NUM_CH-1:0]         txrq;
  logic [NUM_CH-1:0]         abort;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         clk_out;
  logic [NUM_CH-1:0]         tick;
  logic [NUM_CH-1:0]         done;

  int checks = 0;
  int errors = 0;

  pps_burst_clkgen #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .BURST_W(BURST_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .pps      (pps),
    .div_ratio(div_ratio),
    .burst_len(burst_len),
    .txrq     (txrq),
    .abort    (abort),
    .busy     (busy),
    .clk_out  (clk_out),
    .tick     (tick),
    .done     (done)
  );

  // 10 MHz reference clock.
  always #50 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Moves to the next cycle and sits just past the active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Returns during cycle T, the cycle in which the internal pps_edge is high.
  task automatic firePps();
    pps = 1'b1;
    step();
    step();
    pps = 1'b0;
  endtask

  task automatic armChannel(input int ch, input int div, input int len,
                            input logic hold);
    div_ratio[ch*CNT_W +: CNT_W]     = CNT_W'(div);
    burst_len[ch*BURST_W +: BURST_W] = BURST_W'(len);
    txrq[ch] = 1'b1;
    step();
    checkOutput($sformatf("arm ch%0d busy", ch), 32'(busy[ch]), 32'd1);
    if (!hold) txrq[ch] = 1'b0;
  endtask

  task automatic clearAll();
    txrq  = '0;
    abort = '1;
    step();
    abort = '0;
    checkOutput("clear busy", 32'(busy), 32'd0);
  endtask

  // Each comparison packs {busy, clk_out, tick, done} for one channel.
  task automatic applyStimulus(input string tag, input int n, input int pps_at,
                               input logic [63:0] t0, input logic [63:0] c0,
                               input logic [63:0] d0, input logic [63:0] b0,
                               input logic [63:0] t1, input logic [63:0] c1,
                               input logic [63:0] d1, input logic [63:0] b1);
    for (int k = 1; k <= n; k++) begin
      step();
      if (pps_at != 0 && k == pps_at) pps = 1'b1;
      if (pps_at != 0 && k == pps_at + 2) pps = 1'b0;
      checkOutput($sformatf("%s ch0 T+%0d", tag, k),
                  32'({busy[0], clk_out[0], tick[0], done[0]}),
                  32'({b0[k], c0[k], t0[k], d0[k]}));
      checkOutput($sformatf("%s ch1 T+%0d", tag, k),
                  32'({busy[1], clk_out[1], tick[1], done[1]}),
                  32'({b1[k], c1[k], t1[k], d1[k]}));
    end
  endtask

  initial begin
    clock     = 1'b0;
    reset_n   = 1'b0;
    pps       = 1'b0;
    div_ratio = '0;
    burst_len = '0;
    txrq      = '0;
    abort     = '0;
    step();
    step();
    checkOutput("reset outputs", 32'({busy, clk_out, tick, done}), 32'd0);
    reset_n = 1'b1;
    step();
    step();

    // Finite burst with div=4 and len=3, txrq held so the channel re-arms.
    armChannel(0, 4, 3, 1'b1);
    firePps();
    applyStimulus("finite", 14, 0, 64'h444, 64'hCCC, 64'h2000, 64'h5FFE,
                  0, 0, 0, 0);
    clearAll();

    // Odd divide: the high phase is the shorter one.
    armChannel(0, 5, 2, 1'b0);
    firePps();
    applyStimulus("odd5", 12, 0, 64'h84, 64'h18C, 64'h800, 64'h7FE,
                  0, 0, 0, 0);

    // A divide ratio of 0 runs as 2, so clk_out toggles every cycle.
    armChannel(0, 0, 3, 1'b0);
    firePps();
    applyStimulus("div0", 8, 0, 64'h54, 64'h54, 64'h80, 64'h7E,
                  0, 0, 0, 0);

    // abort and pps_edge in the same ARMED cycle: abort wins.
    armChannel(0, 4, 1, 1'b0);
    firePps();
    abort[0] = 1'b1;
    step();
    checkOutput("abort armed outputs", 32'({busy, clk_out, tick, done}), 32'd0);
    abort[0] = 1'b0;
    applyStimulus("after abort armed", 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Abort during the high phase of a running period.
    armChannel(0, 8, 0, 1'b0);
    firePps();
    applyStimulus("run pre abort", 3, 0, 64'h4, 64'hC, 0, 64'hE, 0, 0, 0, 0);
    abort[0] = 1'b1;
    step();
    checkOutput("abort run outputs", 32'({busy, clk_out, tick, done}), 32'd0);
    abort[0] = 1'b0;
    applyStimulus("after abort run", 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Continuous mode: a second PPS during RUN must not shift the phase.
    armChannel(0, 10, 0, 1'b0);
    firePps();
    applyStimulus("continuous", 25, 5, 64'h401004, 64'h3C1F07C, 0,
                  64'h3FFFFFE, 0, 0, 0, 0);
    clearAll();

    // Latching: div_ratio changes during RUN; the next burst picks it up.
    armChannel(0, 4, 4, 1'b1);
    firePps();
    applyStimulus("latch a", 3, 0, 64'h4, 64'hC, 0, 64'hE, 0, 0, 0, 0);
    div_ratio[0 +: CNT_W] = CNT_W'(8);
    applyStimulus("latch b", 15, 0, 64'h888, 64'h1998, 64'h4000, 64'hBFFE,
                  0, 0, 0, 0);
    txrq[0] = 1'b0;
    firePps();
    applyStimulus("latch c", 10, 0, 64'h404, 64'h43C, 0, 64'h7FE, 0, 0, 0, 0);
    clearAll();

    // Two channels armed on the same PPS: first ticks coincide.
    div_ratio = {CNT_W'(7), CNT_W'(3)};
    burst_len = {BURST_W'(1), BURST_W'(2)};
    txrq = 2'b11;
    step();
    checkOutput("multi arm busy", 32'(busy), 32'd3);
    txrq = 2'b00;
    firePps();
    applyStimulus("multi", 9, 0, 64'h24, 64'h24, 64'h80, 64'h7E,
                  64'h4, 64'h1C, 64'h100, 64'hFE);

    // Reset mid-burst clears outputs asynchronously.
    armChannel(0, 4, 0, 1'b1);
    firePps();
    applyStimulus("pre reset", 3, 0, 64'h4, 64'hC, 0, 64'hE, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset outputs", 32'({busy, clk_out, tick, done}), 32'd0);
    txrq = '0;
    step();
    checkOutput("held reset outputs", 32'({busy, clk_out, tick, done}), 32'd0);
    reset_n = 1'b1;
    step();
    firePps();
    applyStimulus("post reset idle", 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    armChannel(0, 4, 0, 1'b0);
    firePps();
    applyStimulus("post reset rearm", 3, 0, 64'h4, 64'hC, 0, 64'hE,
                  0, 0, 0, 0);
    clearAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pps_burst_clkgen.md
Name: pps_burst_clkgen

Overview:
- Multi-channel, PPS-aligned clock and trigger generator that replaces the fixed-ratio divider counters on the 10 MHz reference domain.
- Each channel latches a run-time divide ratio and burst length, arms on a transmit request, and starts exactly on the next PPS rising edge.
- It then emits a 50% duty clock plus one-cycle period ticks for a programmed number of periods, or continuously, and pulses done at the end of the burst.
- The outputs drive the MCU Costas/PSK clock and trigger lines.

Parameters:
NUM_CH, 2, number of independent channels
CNT_W, 24, width of divide-ratio and period counters
BURST_W, 16, width of burst-length field and remaining-period counter

Ports:
clock  input  1  10 MHz reference clock; all logic is on its rising edge
reset_n  input  1  asynchronous active-low reset
pps  input  1  raw 1 Hz pulse, asynchronous to clock
div_ratio  input  NUM_CH*CNT_W  per-channel clock cycles per output period; channel i occupies bits [i*CNT_W +: CNT_W]
burst_len  input  NUM_CH*BURST_W  per-channel periods per burst; 0 means continuous
txrq  input  NUM_CH  per-channel transmit request (level)
abort  input  NUM_CH  per-channel abort (level)
busy  output  NUM_CH  channel is ARMED or RUN
clk_out  output  NUM_CH  generated 50% clock
tick  output  NUM_CH  one-cycle pulse at the start of each period
done  output  NUM_CH  one-cycle pulse when a finite burst completes

Behaviour:
- Reset: one clock, asynchronous active-low reset. While reset_n=0, all channels are IDLE, all counters are 0, the PPS synchroniser flops are 0, and busy, clk_out, tick and done are all 0.
- PPS path: pps passes through a 2-flop synchroniser, then a third flop.
  - pps_edge = sync2 & ~sync3.
  - pps_edge goes high 2–3 clocks after the pps rise and lasts exactly 1 cycle per rise, regardless of the pps high width.
- Per-channel FSM has three states: IDLE, ARMED and RUN.
- IDLE:
  - If txrq=1 and abort=0, go to ARMED next cycle.
  - On that transition, latch div_lat = max(div_ratio_i, 2) and len_lat = burst_len_i.
  - Later changes to div_ratio and burst_len do not affect the armed or running burst.
- ARMED:
  - abort=1 → IDLE.
  - Otherwise, on pps_edge → RUN with cnt=0 and rem=len_lat.
  - If abort and pps_edge occur in the same cycle, abort wins.
- RUN:
  - cnt increments each cycle and wraps to 0 when cnt==div_lat-1.
  - At the wrap, if len_lat≠0, rem decrements. If rem was 1, go to IDLE instead of continuing.
  - pps_edge is ignored in RUN; there is no mid-burst realignment.
  - abort=1 → IDLE next cycle with no done pulse; counters are cleared.
- Outputs are all registered. T denotes the cycle the FSM state is sampled.
  - busy(T+1) = state(T)∈{ARMED, RUN}.
  - tick(T+1) = RUN(T) && cnt(T)==0.
  - clk_out(T+1) = RUN(T) && cnt(T) < div_lat>>1. For odd div_lat the high phase is the shorter one.
  - done(T+1) = RUN(T) && wrap(T) && len_lat≠0 && rem(T)==1.
- Consequences of the above:
  - The first tick and the first clk_out rise happen 1 cycle after the first RUN cycle, and they coincide.
  - done coincides with the first IDLE cycle.
- Re-arm: if txrq is still 1 when the FSM returns to IDLE, the channel re-arms on the next cycle and waits for the next pps_edge. Back-to-back bursts therefore align to successive seconds.
- Channels are fully independent. They share only pps_edge.
- Widths:
  - cnt is CNT_W bits; rem is BURST_W bits.
  - div_ratio values 0 and 1 are coerced to 2.
  - Continuous mode (len_lat=0) never decrements rem and never asserts done.
- Reset asserted mid-burst clears everything immediately. On reset release, nothing runs until a new txrq followed by a pps_edge.

Test Plan:
1. Finite burst: div=4, len=3, txrq held; pps_edge at cycle T.
   - RUN from T+1 to T+12.
   - tick at T+2, T+6, T+10; clk_out high at T+2–3, T+6–7, T+10–11.
   - done at T+13, where busy=0; re-armed (busy=1) at T+14.
2. Odd and degenerate divide:
   - div=5, len=2: clk_out high 2 cycles, low 3 cycles per period; exactly 2 ticks.
   - div=0: behaves as div=2; clk_out toggles every cycle.
3. Arm/abort races:
   - abort and pps_edge in the same ARMED cycle → stays out of RUN, no tick, busy=0 next cycle.
   - abort at a RUN mid-period → clk_out and busy drop 1 cycle later, no done.
4. Continuous mode: len=0, div=10 → a tick every 10 cycles across two pps edges with no phase shift; done is never asserted.
5. Parameter latching: change div_ratio from 4 to 8 while RUN (len=4) → all 4 periods remain 4 cycles; the next burst after re-arm uses 8.
6. Multi-channel and reset:
   - ch0 div=3, ch1 div=7 armed on the same pps → both first ticks occur in the same cycle.
   - reset_n pulsed low mid-burst → all outputs 0 asynchronously; no activity until txrq followed by a new pps.
